// File: rtl/inst_rom_resp.sv
// ---------------------------------------------------------------------------
// inst_rom_resp
// Instruction-memory responder for the fetch port. A fetch request
// (inst_ena/inst_addra) is answered one cycle later on inst_douta, which
// matches synchronous-read BRAM timing. The backing word array is filled at
// boot by a streaming valid/ready loader. Fetches are blocked while a load
// is in progress.
//
// Ports
//   clk         : clock, all logic on posedge
//   rst         : synchronous active-high reset (array contents survive it)
//   inst_ena    : fetch enable
//   inst_addra  : fetch byte address (64-bit)
//   inst_douta  : registered fetched instruction
//   inst_fault  : registered, high when the answered address was misaligned
//                 or outside the array window
//   ld_start    : pulse, begin (or restart) a load at word index 0
//   ld_valid    : loader word valid
//   ld_data     : loader word
//   ld_last     : final word of the image
//   ld_ready    : loader may transfer this cycle
//   ld_busy     : a load is in progress
//   ld_count    : words written in the current/last load
// ---------------------------------------------------------------------------
module inst_rom_resp #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_ena,
  input  logic [63:0]              inst_addra,
  output logic [31:0]              inst_douta,
  output logic                     inst_fault,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     ld_busy,
  output logic [$clog2(DEPTH):0]   ld_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Size of the array window in bytes, and the count values that mark a
  // full array and the final free slot.
  localparam logic [63:0]   SPAN     = 64'(DEPTH) << 2;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   douta_q, douta_d;
  logic          fault_q, fault_d;

  logic [31:0]   mem [DEPTH];

  logic          xfer;
  logic [63:0]   offset;
  logic          fetchOk;
  logic [AW-1:0] fetchIdx;

  // State register plus the loader count and the fetch response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      douta_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      douta_q <= douta_d;
      fault_q <= fault_d;
    end
  end

  // The array has no reset. Contents must survive rst, so an interrupted
  // load leaves a partially written image behind.
  always_ff @(posedge clk) begin
    if (!rst && xfer) begin
      mem[count_q[AW-1:0]] <= ld_data;
    end
  end

  // Next-state logic. Reaching the last slot ends the load even without
  // ld_last. A ld_start in any state restarts loading from index 0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ld_start) state_d = LOAD;
      LOAD: begin
        if (ld_start) begin
          state_d = LOAD;
        end else if (count_q == FULL) begin
          state_d = DONE;
        end else if (xfer && (ld_last || count_q == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: if (ld_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Loader handshake outputs. A restart pulse suppresses the write in the
  // same cycle, so the new image always begins at index 0.
  always_comb begin
    ld_busy  = (state_q == LOAD);
    ld_ready = (state_q == LOAD) && (count_q != FULL);
    xfer     = ld_ready && ld_valid && !ld_start;
  end

  // Word counter: cleared by ld_start, bumped once per accepted word.
  always_comb begin
    count_d = count_q;
    if (ld_start) begin
      count_d = '0;
    end else if (xfer) begin
      count_d = count_q + CW'(1);
    end
  end

  // Fetch decode. Subtracting the base wraps addresses below it to a huge
  // offset, so they land out of range instead of aliasing into the array.
  always_comb begin
    offset   = inst_addra - BASE_ADDR;
    fetchOk  = (offset < SPAN) && (inst_addra[1:0] == 2'b00);
    fetchIdx = offset[AW+1:2];
    douta_d  = douta_q;
    fault_d  = fault_q;
    if (inst_ena) begin
      if (state_q == LOAD) begin
        douta_d = NOP_INSTR;
        fault_d = 1'b0;
      end else if (fetchOk) begin
        douta_d = mem[fetchIdx];
        fault_d = 1'b0;
      end else begin
        douta_d = NOP_INSTR;
        fault_d = 1'b1;
      end
    end
  end

  assign inst_douta = douta_q;
  assign inst_fault = fault_q;
  assign ld_count   = count_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_resp
// Self-checking bench for inst_rom_resp. A behavioural model holds the
// image as a plain array plus a "loading" flag and a word count. The model
// predicts every registered output after each clock edge. Directed steps
// cover reset, loading, fetch, faults, a full array and disrupted loads.
// A randomized phase follows the directed steps.
// ---------------------------------------------------------------------------
module tb_inst_rom_resp;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ena;
  logic [63:0] inst_addra;
  logic [31:0] inst_douta;
  logic        inst_fault;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_busy;
  logic [12:0] ld_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] refMem   [DEPTH];
  bit          refKnown [DEPTH];
  bit          mLoading;
  int          mCount;
  logic [31:0] mDouta;
  bit          mFault;
  bit          mDataKnown;

  inst_rom_resp dut (
    .clk        (clk),
    .rst        (rst),
    .inst_ena   (inst_ena),
    .inst_addra (inst_addra),
    .inst_douta (inst_douta),
    .inst_fault (inst_fault),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_busy    (ld_busy),
    .ld_count   (ld_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelUpdate();
    logic [63:0] off;
    int          idx;
    if (rst) begin
      mDouta     = NOP;
      mFault     = 0;
      mDataKnown = 1;
      mLoading   = 0;
      mCount     = 0;
    end else begin
      if (inst_ena) begin
        off = inst_addra - BASE;
        if (mLoading) begin
          mDouta = NOP; mFault = 0; mDataKnown = 1;
        end else if (off < 64'(DEPTH * 4) && inst_addra[1:0] == 2'b00) begin
          idx        = int'(off >> 2);
          mDouta     = refMem[idx];
          mFault     = 0;
          mDataKnown = refKnown[idx];
        end else begin
          mDouta = NOP; mFault = 1; mDataKnown = 1;
        end
      end
      if (ld_start) begin
        mLoading = 1;
        mCount   = 0;
      end else if (mLoading && ld_valid && mCount < DEPTH) begin
        refMem[mCount]   = ld_data;
        refKnown[mCount] = 1;
        mCount++;
        if (ld_last || mCount == DEPTH) mLoading = 0;
      end
    end
  endtask

  task automatic checkOutput();
    if (mDataKnown) checkVal("douta", 64'(inst_douta), 64'(mDouta));
    checkVal("fault", 64'(inst_fault), 64'(mFault));
    checkVal("ready", 64'(ld_ready), 64'(mLoading && mCount < DEPTH));
    checkVal("busy", 64'(ld_busy), 64'(mLoading));
    checkVal("count", 64'(ld_count), 64'(mCount));
  endtask

  // Drives one cycle of inputs, clocks, updates the model and checks 1ns later.
  task automatic applyStimulus(input logic r, input logic e, input logic [63:0] a,
                               input logic s, input logic v, input logic [31:0] d,
                               input logic l);
    rst = r; inst_ena = e; inst_addra = a;
    ld_start = s; ld_valid = v; ld_data = d; ld_last = l;
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput();
  endtask

  task automatic fetch(input logic [63:0] a);
    applyStimulus(0, 1, a, 0, 0, 32'h0, 0);
  endtask

  initial begin
    int sel;
    logic [63:0] a;
    for (int i = 0; i < DEPTH; i++) refKnown[i] = 0;
    mLoading = 0; mCount = 0; mDouta = NOP; mFault = 0; mDataKnown = 1;

    // Reset held for two cycles.
    applyStimulus(1, 0, 64'h0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 64'h0, 0, 0, 32'h0, 0);
    checkVal("rst_douta", 64'(inst_douta), 64'h13);
    checkVal("rst_fault", 64'(inst_fault), 64'h0);
    checkVal("rst_busy", 64'(ld_busy), 64'h0);
    checkVal("rst_ready", 64'(ld_ready), 64'h0);

    // Three-word image with ld_last on the final word.
    applyStimulus(0, 0, 64'h0, 1, 0, 32'h0, 0);
    applyStimulus(0, 0, 64'h0, 0, 1, 32'hAAAA_0001, 0);
    applyStimulus(0, 0, 64'h0, 0, 1, 32'hAAAA_0002, 0);
    applyStimulus(0, 0, 64'h0, 0, 1, 32'hAAAA_0003, 1);
    checkVal("load3_count", 64'(ld_count), 64'd3);
    checkVal("load3_busy", 64'(ld_busy), 64'h0);
    fetch(64'h8000_0004);
    checkVal("load3_fetch", 64'(inst_douta), 64'hAAAA_0002);
    checkVal("load3_fault", 64'(inst_fault), 64'h0);

    // Back-to-back fetches, then hold with ena low.
    fetch(64'h8000_0000);
    checkVal("b2b_0", 64'(inst_douta), 64'hAAAA_0001);
    fetch(64'h8000_0008);
    checkVal("b2b_1", 64'(inst_douta), 64'hAAAA_0003);
    fetch(64'h8000_0004);
    checkVal("b2b_2", 64'(inst_douta), 64'hAAAA_0002);
    applyStimulus(0, 0, 64'h8000_0000, 0, 0, 32'h0, 0);
    checkVal("hold", 64'(inst_douta), 64'hAAAA_0002);

    // Misaligned, below-base and past-end fetches fault and return NOP.
    fetch(64'h8000_0002);
    checkVal("mis_douta", 64'(inst_douta), 64'h13);
    checkVal("mis_fault", 64'(inst_fault), 64'h1);
    fetch(64'h7FFF_FFFC);
    checkVal("below_douta", 64'(inst_douta), 64'h13);
    checkVal("below_fault", 64'(inst_fault), 64'h1);
    fetch(64'h8000_4000);
    checkVal("end_douta", 64'(inst_douta), 64'h13);
    checkVal("end_fault", 64'(inst_fault), 64'h1);
    fetch(64'h8000_0000);
    checkVal("recover_fault", 64'(inst_fault), 64'h0);
    checkVal("recover_douta", 64'(inst_douta), 64'hAAAA_0001);

    // Overfill: DEPTH+2 words with no ld_last. Extra words are dropped.
    applyStimulus(0, 0, 64'h0, 1, 0, 32'h0, 0);
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(0, 0, 64'h0, 0, 1, 32'hC000_0000 | 32'(i), 0);
    checkVal("full_count", 64'(ld_count), 64'd4096);
    checkVal("full_ready", 64'(ld_ready), 64'h0);
    checkVal("full_busy", 64'(ld_busy), 64'h0);
    fetch(BASE + 64'(4 * (DEPTH - 1)));
    checkVal("full_lastword", 64'(inst_douta), 64'hC000_0FFF);
    fetch(BASE + 64'd400);
    checkVal("full_word100", 64'(inst_douta), 64'hC000_0064);

    // Restart after five words, then a reset in the middle of a load.
    applyStimulus(0, 0, 64'h0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, BASE, 0, 1, 32'hD600_0000 | 32'(i), 0);
    checkVal("ld_fetch_blocked", 64'(inst_douta), 64'h13);
    applyStimulus(0, 0, 64'h0, 1, 1, 32'hDEAD_BEEF, 0);
    checkVal("restart_count", 64'(ld_count), 64'd0);
    checkVal("restart_ready", 64'(ld_ready), 64'h1);
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 0, 64'h0, 0, 1, 32'hE600_0000 | 32'(i), 0);
    applyStimulus(1, 0, 64'h0, 0, 1, 32'hBAD0_BAD0, 0);
    checkVal("midrst_busy", 64'(ld_busy), 64'h0);
    checkVal("midrst_count", 64'(ld_count), 64'd0);
    fetch(BASE);
    checkVal("keep_w0", 64'(inst_douta), 64'hE600_0000);
    fetch(BASE + 64'd12);
    checkVal("keep_w3", 64'(inst_douta), 64'hD600_0003);
    fetch(BASE + 64'd40);
    checkVal("keep_w10", 64'(inst_douta), 64'hC000_000A);

    // Randomized traffic mixing fetches, loads, restarts and resets.
    for (int n = 0; n < 800; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
        1:       a = BASE - 64'(4 * $urandom_range(1, 8));
        2:       a = BASE + 64'(DEPTH * 4) + 64'(4 * $urandom_range(0, 8));
        default: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      applyStimulus($urandom_range(0, 99) == 0, 1'($urandom), a,
                    $urandom_range(0, 99) < 3, 1'($urandom), $urandom,
                    $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
